// File: rtl/clock_ctrl.sv
// clock_ctrl: 1 Hz tick generation, button debouncing and the RUN/ADJUST mode
// FSM of the digital clock. It drives per-field enable strobes, the shared
// count direction, the current mode and the blink control for the display.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | free-running time keeping; each tick advances the seconds
// ADJ_MIN | seconds frozen; up/down step the minutes field
// ADJ_HR  | seconds frozen; up/down step the hours field
module clock_ctrl #(
  parameter int TICK_DIV  = 100_000_000,
  parameter int DB_CYCLES = 2_000_000,
  parameter int DB_W      = 21,
  parameter int DIV_W     = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       sec_last,
  input  logic       min_last,
  output logic       sec_en,
  output logic       min_en,
  output logic       hr_en,
  output logic       updown,
  output logic [1:0] mode,
  output logic       blink
);

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_ADJ_MIN = 2'b01;
  localparam logic [1:0] MODE_ADJ_HR  = 2'b10;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(TICK_DIV / 2);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);

  // Button bit positions within the packed vectors below.
  localparam int B_C = 0;
  localparam int B_L = 1;
  localparam int B_R = 2;
  localparam int B_U = 3;
  localparam int B_D = 4;

  logic [4:0]       btn_raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       db_level;
  logic [4:0]       press;
  logic [DB_W-1:0]  db_cnt [5];

  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_nxt;
  logic             tick;

  logic [1:0]       mode_q;
  logic [1:0]       mode_nxt;
  logic             stb_sec;
  logic             stb_min;
  logic             stb_hr;
  logic             stb_down;

  logic             p_c;
  logic             p_lr;
  logic             p_u;
  logic             p_d;

  assign btn_raw = {btn_d, btn_u, btn_r, btn_l, btn_c};
  assign tick    = (presc == DIV_LAST);
  assign mode    = mode_q;

  assign p_c  = press[B_C];
  assign p_lr = press[B_L] | press[B_R];
  assign p_u  = press[B_U];
  assign p_d  = press[B_D];

  // Synchronise each button, debounce it, and emit a one-cycle pulse on a debounced rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      press    <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]   <= '0;
          db_level[i] <= sync2[i];
          press[i]    <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Mode transitions and strobe requests; a centre press wins and suppresses any strobe.
  always_comb begin
    mode_nxt = mode_q;
    stb_sec  = 1'b0;
    stb_min  = 1'b0;
    stb_hr   = 1'b0;
    stb_down = 1'b0;
    case (mode_q)
      MODE_RUN: begin
        if (p_c) begin
          mode_nxt = MODE_ADJ_MIN;
        end else if (tick) begin
          stb_sec = 1'b1;
          stb_min = sec_last;
          stb_hr  = sec_last & min_last;
        end
      end
      MODE_ADJ_MIN: begin
        if (p_c) begin
          mode_nxt = MODE_RUN;
        end else if (p_lr) begin
          mode_nxt = MODE_ADJ_HR;
        end else if (p_u ^ p_d) begin
          stb_min  = 1'b1;
          stb_down = p_d;
        end
      end
      MODE_ADJ_HR: begin
        if (p_c) begin
          mode_nxt = MODE_RUN;
        end else if (p_lr) begin
          mode_nxt = MODE_ADJ_MIN;
        end else if (p_u ^ p_d) begin
          stb_hr   = 1'b1;
          stb_down = p_d;
        end
      end
      default: mode_nxt = MODE_RUN;
    endcase
  end

  // Next prescaler value; re-entering RUN restarts the second so it is full length.
  always_comb begin
    if ((mode_nxt == MODE_RUN) && (mode_q != MODE_RUN)) begin
      presc_nxt = '0;
    end else if (tick) begin
      presc_nxt = '0;
    end else begin
      presc_nxt = presc + DIV_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) presc <= '0;
    else       presc <= presc_nxt;
  end

  // Registered outputs: mode, enables, direction and blink all settle together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_RUN;
      sec_en <= 1'b0;
      min_en <= 1'b0;
      hr_en  <= 1'b0;
      updown <= 1'b1;
      blink  <= 1'b1;
    end else begin
      mode_q <= mode_nxt;
      sec_en <= stb_sec;
      min_en <= stb_min;
      hr_en  <= stb_hr;
      updown <= ~stb_down;
      blink  <= (mode_nxt == MODE_RUN) | (presc_nxt < DIV_HALF);
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: table-driven run-mode vectors plus directed button sequences
// for clock_ctrl with TICK_DIV=10 and DB_CYCLES=4.
module tb_clock_ctrl;

  localparam int TICK_DIV  = 10;
  localparam int DB_CYCLES = 4;

  typedef struct {
    logic       sl;
    logic       ml;
    logic [6:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [4:0] btn;
  logic       sl;
  logic       ml;
  logic       sec_en;
  logic       min_en;
  logic       hr_en;
  logic       updown;
  logic [1:0] mode;
  logic       blink;

  int n_vec;
  int n_miss;
  int cyc;
  int s;

  vec_t vecs [30];

  clock_ctrl #(
    .TICK_DIV (TICK_DIV),
    .DB_CYCLES(DB_CYCLES),
    .DB_W     (3),
    .DIV_W    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_c   (btn[0]),
    .btn_l   (btn[1]),
    .btn_r   (btn[2]),
    .btn_u   (btn[3]),
    .btn_d   (btn[4]),
    .sec_last(sl),
    .min_last(ml),
    .sec_en  (sec_en),
    .min_en  (min_en),
    .hr_en   (hr_en),
    .updown  (updown),
    .mode    (mode),
    .blink   (blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pack(input logic [2:0] en, input logic ud,
                                      input logic [1:0] m, input logic bl);
    return {en, ud, m, bl};
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {sec_en, min_en, hr_en, updown, mode, blink};
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d {sec,min,hr,ud,mode,blink} got=%b want=%b",
               name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [4:0] held);
    @(negedge clk);
    reset = 1'b1;
    btn   = held;
    sl    = 1'b0;
    ml    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset_values", pack(3'b000, 1'b1, 2'b00, 1'b1));
    reset = 1'b0;
    cyc   = 0;
  endtask

  // Expected blink in adjust assumes the prescaler has run freely since reset.
  task automatic run_check(input string name, input int n,
                           input logic [1:0] m_a, input logic [1:0] m_b, input int sw_at,
                           input logic [2:0] en_bits, input logic ud, input int en_at);
    logic [1:0] em;
    logic [2:0] ee;
    logic       eu;
    logic       eb;
    for (int k = 0; k < n; k++) begin
      step();
      em = (sw_at >= 0 && cyc >= sw_at) ? m_b : m_a;
      ee = (cyc == en_at) ? en_bits : 3'b000;
      eu = (cyc == en_at) ? ud : 1'b1;
      eb = (em == 2'b00) ? 1'b1 : ((cyc % TICK_DIV) < (TICK_DIV / 2));
      check(name, {ee, eu, em, eb});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    cyc    = 0;
    reset  = 1'b1;
    btn    = '0;
    sl     = 1'b0;
    ml     = 1'b0;

    for (int k = 0; k < 30; k++)
      vecs[k] = '{sl: 1'b0, ml: 1'b0, exp: pack(3'b000, 1'b1, 2'b00, 1'b1)};
    vecs[9].exp  = pack(3'b100, 1'b1, 2'b00, 1'b1);
    vecs[15].sl  = 1'b1;
    vecs[15].ml  = 1'b1;
    vecs[19].sl  = 1'b1;
    vecs[19].ml  = 1'b1;
    vecs[19].exp = pack(3'b111, 1'b1, 2'b00, 1'b1);
    vecs[29].sl  = 1'b1;
    vecs[29].exp = pack(3'b110, 1'b1, 2'b00, 1'b1);

    // Free-running tick and carry cascade.
    do_reset(5'b00000);
    for (int k = 0; k < 30; k++) begin
      sl = vecs[k].sl;
      ml = vecs[k].ml;
      step();
      check("run_table", vecs[k].exp);
    end
    sl = 1'b0;
    ml = 1'b0;

    // Bouncing centre button gives a single press, mode change at cycle 9.
    do_reset(5'b00000);
    btn[0] = 1'b1;
    step();
    check("c_bounce_1", pack(3'b000, 1'b1, 2'b00, 1'b1));
    btn[0] = 1'b0;
    step();
    check("c_bounce_0", pack(3'b000, 1'b1, 2'b00, 1'b1));
    btn[0] = 1'b1;
    run_check("c_bounce_held", 28, 2'b00, 2'b01, 9, 3'b000, 1'b1, -1);
    btn = '0;
    run_check("c_release", 8, 2'b01, 2'b01, -1, 3'b000, 1'b1, -1);

    // Adjust minutes down, move to hours, adjust hours up.
    s = cyc;
    btn[4] = 1'b1;
    run_check("adj_min_down", 10, 2'b01, 2'b01, -1, 3'b010, 1'b0, s + 7);
    btn = '0;
    run_check("d_release", 8, 2'b01, 2'b01, -1, 3'b000, 1'b1, -1);
    s = cyc;
    btn[2] = 1'b1;
    run_check("r_to_hr", 10, 2'b01, 2'b10, s + 7, 3'b000, 1'b1, -1);
    btn = '0;
    run_check("r_release", 8, 2'b10, 2'b10, -1, 3'b000, 1'b1, -1);
    s = cyc;
    btn[3] = 1'b1;
    run_check("adj_hr_up", 10, 2'b10, 2'b10, -1, 3'b001, 1'b1, s + 7);
    btn = '0;
    run_check("u_release", 8, 2'b10, 2'b10, -1, 3'b000, 1'b1, -1);

    // Simultaneous up/down cancels; centre overrides up and restarts the second.
    btn[3] = 1'b1;
    btn[4] = 1'b1;
    run_check("ud_same", 10, 2'b10, 2'b10, -1, 3'b000, 1'b1, -1);
    btn = '0;
    run_check("ud_release", 8, 2'b10, 2'b10, -1, 3'b000, 1'b1, -1);
    s = cyc;
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    run_check("c_u_same", 20, 2'b10, 2'b00, s + 7, 3'b100, 1'b1, s + 17);
    btn = '0;
    run_check("c_u_release", 8, 2'b00, 2'b00, -1, 3'b100, 1'b1, s + 27);

    // Centre held through reset, left switches field, async reset drops a pending press.
    do_reset(5'b00001);
    run_check("c_held_reset", 10, 2'b00, 2'b01, 7, 3'b000, 1'b1, -1);
    btn = '0;
    run_check("c_held_release", 8, 2'b01, 2'b01, -1, 3'b000, 1'b1, -1);
    s = cyc;
    btn[1] = 1'b1;
    run_check("l_to_hr", 10, 2'b01, 2'b10, s + 7, 3'b000, 1'b1, -1);
    btn = '0;
    run_check("l_release", 8, 2'b10, 2'b10, -1, 3'b000, 1'b1, -1);
    btn[3] = 1'b1;
    run_check("u_pending", 3, 2'b10, 2'b10, -1, 3'b000, 1'b1, -1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", pack(3'b000, 1'b1, 2'b00, 1'b1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    run_check("u_after_reset", 14, 2'b00, 2'b00, -1, 3'b100, 1'b1, 10);
    btn = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
